// File: rtl/regwr_arbiter_if.sv
`default_nettype none
// regwr_arbiter_if: two valid/ready writeback request ports plus the registered
// register-file write port. The arbiter uses the slave modport; the requesters use master.

interface regwr_arbiter_if;
  logic        a_valid_i;
  logic [4:0]  a_waddr_i;
  logic [31:0] a_wdata_i;
  logic        a_ready_o;
  logic        b_valid_i;
  logic [4:0]  b_waddr_i;
  logic [31:0] b_wdata_i;
  logic        b_ready_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        b_forced_o;

  modport slave (
    input  a_valid_i, a_waddr_i, a_wdata_i,
    input  b_valid_i, b_waddr_i, b_wdata_i,
    output a_ready_o, b_ready_o,
    output we_o, waddr_o, wdata_o, b_forced_o
  );

  modport master (
    output a_valid_i, a_waddr_i, a_wdata_i,
    output b_valid_i, b_waddr_i, b_wdata_i,
    input  a_ready_o, b_ready_o,
    input  we_o, waddr_o, wdata_o, b_forced_o
  );
endinterface

`default_nettype wire

// File: rtl/regwr_arbiter.sv
`default_nettype none
// regwr_arbiter: shares one register-file write port between pipeline writeback (A)
// and a multi-cycle unit (B). Define REGWR_STARVE_GUARD_EN for the B starvation guard.

module regwr_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input logic            clk,
  input logic            reset,
  regwr_arbiter_if.slave bus
);

  if (MAX_WAIT < 1 || MAX_WAIT > (1 << CNT_W) - 1) begin : g_bad_max_wait
    $error("regwr_arbiter: MAX_WAIT does not fit the starvation counter");
  end

  logic        a_zero;
  logic        b_zero;
  logic        a_req;
  logic        b_req;
  logic        force_b;
  logic        grant_a;
  logic        grant_b;
  logic        grant;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // Writes to r0 are accepted and dropped; they never compete for the port.
  assign a_zero = bus.a_valid_i && (bus.a_waddr_i == 5'd0);
  assign b_zero = bus.b_valid_i && (bus.b_waddr_i == 5'd0);
  assign a_req  = bus.a_valid_i && (bus.a_waddr_i != 5'd0);
  assign b_req  = bus.b_valid_i && (bus.b_waddr_i != 5'd0);

`ifdef REGWR_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt;

  assign force_b = a_req && b_req && (starve_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!b_req || grant_b) begin
      starve_cnt <= '0;
    end else if (starve_cnt != WAIT_LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign force_b = 1'b0;
`endif

  assign grant_a  = a_req && !force_b;
  assign grant_b  = b_req && (!a_req || force_b);
  assign grant    = grant_a || grant_b;
  assign sel_addr = grant_b ? bus.b_waddr_i : bus.a_waddr_i;
  assign sel_data = grant_b ? bus.b_wdata_i : bus.a_wdata_i;

  // Gating with reset keeps any handshake from completing while reset is high.
  assign bus.a_ready_o = !reset && (a_zero || grant_a);
  assign bus.b_ready_o = !reset && (b_zero || grant_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.we_o       <= 1'b0;
      bus.waddr_o    <= 5'd0;
      bus.wdata_o    <= 32'd0;
      bus.b_forced_o <= 1'b0;
    end else begin
      bus.we_o       <= grant;
      bus.b_forced_o <= force_b;
      if (grant) begin
        bus.waddr_o <= sel_addr;
        bus.wdata_o <= sel_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regwr_arbiter.sv
`default_nettype none
// tb_regwr_arbiter: directed checks of regwr_arbiter handshakes, arbitration,
// zero-address absorb, reset cancellation and write ordering.

module tb_regwr_arbiter;

`ifdef REGWR_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] rf [32];
  logic bwin;

  regwr_arbiter_if bus();

  regwr_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow register file fed by the DUT write port.
  always @(posedge clk) begin
    if (bus.we_o === 1'b1) rf[bus.waddr_o] <= bus.wdata_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] addr, input logic [31:0] data);
    bus.a_valid_i = v;
    bus.a_waddr_i = addr;
    bus.a_wdata_i = data;
  endtask

  task automatic set_b(input logic v, input logic [4:0] addr, input logic [31:0] data);
    bus.b_valid_i = v;
    bus.b_waddr_i = addr;
    bus.b_wdata_i = data;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;

    // Reset with requests present: no readies, outputs cleared.
    reset = 1'b1;
    set_a(1'b1, 5'd5, 32'h0000_0001);
    set_b(1'b1, 5'd9, 32'h0000_0002);
    repeat (2) tick();
    check("rst_we", bus.we_o, 32'd0);
    check("rst_waddr", bus.waddr_o, 32'd0);
    check("rst_wdata", bus.wdata_o, 32'd0);
    check("rst_bforced", bus.b_forced_o, 32'd0);
    check("rst_a_ready", bus.a_ready_o, 32'd0);
    check("rst_b_ready", bus.b_ready_o, 32'd0);
    reset = 1'b0;
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    tick();
    check("idle_we", bus.we_o, 32'd0);

    // Only A valid.
    set_a(1'b1, 5'd5, 32'h1234_5678);
    #1;
    check("aonly_a_ready", bus.a_ready_o, 32'd1);
    check("aonly_b_ready", bus.b_ready_o, 32'd0);
    tick();
    set_a(1'b0, 5'd0, 32'd0);
    check("aonly_we", bus.we_o, 32'd1);
    check("aonly_waddr", bus.waddr_o, 32'd5);
    check("aonly_wdata", bus.wdata_o, 32'h1234_5678);
    tick();
    check("hold_we", bus.we_o, 32'd0);
    check("hold_waddr", bus.waddr_o, 32'd5);
    check("hold_wdata", bus.wdata_o, 32'h1234_5678);

    // A to r0 absorbed while B to r9 is granted.
    set_a(1'b1, 5'd0, 32'hDEAD_BEEF);
    set_b(1'b1, 5'd9, 32'h9999_0009);
    #1;
    check("abs_a_ready", bus.a_ready_o, 32'd1);
    check("abs_b_ready", bus.b_ready_o, 32'd1);
    tick();
    check("abs_we", bus.we_o, 32'd1);
    check("abs_waddr", bus.waddr_o, 32'd9);
    check("abs_wdata", bus.wdata_o, 32'h9999_0009);

    // Both to r0: both ready, nothing written.
    set_b(1'b1, 5'd0, 32'hCAFE_0000);
    #1;
    check("z2_a_ready", bus.a_ready_o, 32'd1);
    check("z2_b_ready", bus.b_ready_o, 32'd1);
    tick();
    check("z2_we", bus.we_o, 32'd0);
    check("z2_waddr", bus.waddr_o, 32'd9);

    // A and B contend for 10 cycles; with the guard B wins every fifth cycle.
    set_a(1'b1, 5'd3, 32'hA0A0_0003);
    set_b(1'b1, 5'd7, 32'hB0B0_0007);
    for (int i = 0; i < 10; i++) begin
      #1;
      bwin = GUARD && ((i % 5) == 4);
      check($sformatf("cont%0d_a_ready", i), bus.a_ready_o, {31'd0, !bwin});
      check($sformatf("cont%0d_b_ready", i), bus.b_ready_o, {31'd0, bwin});
      tick();
      check($sformatf("cont%0d_we", i), bus.we_o, 32'd1);
      check($sformatf("cont%0d_waddr", i), bus.waddr_o, bwin ? 32'd7 : 32'd3);
      check($sformatf("cont%0d_bforced", i), bus.b_forced_o, {31'd0, bwin});
    end

    // A drops: B wins on its own, not forced.
    set_a(1'b0, 5'd0, 32'd0);
    #1;
    check("bonly_b_ready", bus.b_ready_o, 32'd1);
    tick();
    set_b(1'b0, 5'd0, 32'd0);
    check("bonly_waddr", bus.waddr_o, 32'd7);
    check("bonly_wdata", bus.wdata_o, 32'hB0B0_0007);
    check("bonly_bforced", bus.b_forced_o, 32'd0);

    // Reset in the same cycle as an A grant cancels it; A completes afterwards.
    set_a(1'b1, 5'd6, 32'h6666_6666);
    reset = 1'b1;
    #1;
    check("rg_a_ready_in_rst", bus.a_ready_o, 32'd0);
    tick();
    check("rg_we", bus.we_o, 32'd0);
    check("rg_waddr", bus.waddr_o, 32'd0);
    check("rg_a_ready", bus.a_ready_o, 32'd0);
    check("rg_b_ready", bus.b_ready_o, 32'd0);
`ifdef REGWR_STARVE_GUARD_EN
    check("rg_starve_cnt", {29'd0, dut.starve_cnt}, 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("rg_a_ready_after", bus.a_ready_o, 32'd1);
    tick();
    set_a(1'b0, 5'd0, 32'd0);
    check("rg_we_after", bus.we_o, 32'd1);
    check("rg_waddr_after", bus.waddr_o, 32'd6);
    check("rg_wdata_after", bus.wdata_o, 32'h6666_6666);

    // Same destination r12: A first, then B; B's data is final.
    set_a(1'b1, 5'd12, 32'hAAAA_AAAA);
    set_b(1'b1, 5'd12, 32'hBBBB_BBBB);
    #1;
    check("same_a_ready", bus.a_ready_o, 32'd1);
    check("same_b_ready", bus.b_ready_o, 32'd0);
    tick();
    set_a(1'b0, 5'd0, 32'd0);
    check("same_first_wdata", bus.wdata_o, 32'hAAAA_AAAA);
    #1;
    check("same_b_ready2", bus.b_ready_o, 32'd1);
    tick();
    set_b(1'b0, 5'd0, 32'd0);
    check("same_second_waddr", bus.waddr_o, 32'd12);
    check("same_second_wdata", bus.wdata_o, 32'hBBBB_BBBB);
    tick();
    check("same_idle_we", bus.we_o, 32'd0);
    check("rf12_final", rf[12], 32'hBBBB_BBBB);
    check("rf0_untouched", rf[0], 32'd0);
    check("rf6_final", rf[6], 32'h6666_6666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regwr_arbiter.md
# regwr_arbiter

Arbitrates the single register-file write port between two writeback sources: the in-order pipeline writeback stage (port A) and a multi-cycle execution unit such as divide or late load return (port B). Each source uses a valid/ready handshake; the block selects at most one write per cycle, drives a registered write to the register file's `we`/`waddr`/`wdata` inputs, and guarantees port B forward progress with a starvation counter. Writes to register 0 are absorbed without consuming the write port.

## Interface
- `MAX_WAIT`, 4: cycles port B may be refused while valid before it is forced to win; legal range 1..(2^`CNT_W`-1)
- `CNT_W`, 3: width of the starvation counter

- `clk` in 1: clock
- `reset` in 1: synchronous, active-high reset
- `a_valid_i` in 1: port A write request
- `a_waddr_i` in 5: port A destination register
- `a_wdata_i` in 32: port A write data
- `a_ready_o` out 1: port A request accepted this cycle
- `b_valid_i` in 1: port B write request
- `b_waddr_i` in 5: port B destination register
- `b_wdata_i` in 32: port B write data
- `b_ready_o` out 1: port B request accepted this cycle
- `we_o` out 1: register-file write enable
- `waddr_o` out 5: register-file write address
- `wdata_o` out 32: register-file write data
- `b_forced_o` out 1: registered; 1 for one cycle after a starvation-forced B grant

## Operation
- Handshake: a transfer occurs on a port when valid && ready in the same cycle. The requester holds valid, waddr, and wdata stable until ready. `ready` is combinational from the valid inputs and the counter, and never depends on its own port's data.
- Zero-address absorb: a valid request with waddr == 0 gets ready = 1 in the same cycle. It is dropped (no write issued) and never competes for the port, so the other port may be granted in the same cycle.
- Arbitration among nonzero-address requests:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant A, unless `starve_cnt` == `MAX_WAIT`. In that case grant B and hold `a_ready_o` = 0.
- Starvation counter `starve_cnt` (`CNT_W` bits):
  - Clears when B has no nonzero valid request, or when B is granted.
  - Otherwise increments.
  - Saturates at `MAX_WAIT`.
- Write issue: on a grant, the next cycle drives `we_o` = 1 with the granted waddr/wdata. Otherwise `we_o` = 0, and `waddr_o`/`wdata_o` hold their last values.
- Reset:
  - Outputs: `we_o` = 0, `waddr_o` = 0, `wdata_o` = 0, `b_forced_o` = 0; `a_ready_o` = `b_ready_o` = 0 while `reset` is high.
  - Internal: `starve_cnt` = 0.
  - A reset asserted in the same cycle as a grant cancels that grant: no write is issued after reset, and no handshake completes during reset.

## Timing
- Grant to register-file write: 1 cycle. A request accepted at edge N appears on `we_o` between edges N and N+1 and is written at edge N+1.
- Read-during-write bypass remains the register file's job.
- Throughput: one nonzero write per cycle.
- Port B worst-case wait from valid to ready, with A continuously valid and nonzero: `MAX_WAIT` + 1 cycles.
- Simultaneous events:
  - Both ports target the same nonzero address: A wins, or B if forced. The loser is written one or more cycles later, so the later grant is the final register value.
  - Both ports target address 0: both ready, no write.

## Configuration
- `REGWR_STARVE_GUARD_EN`:
  - Defined: starvation counter and forced B grant as above; `b_forced_o` functional.
  - Undefined: strict A priority; `starve_cnt` is removed; `b_forced_o` is tied to 0; port B can starve indefinitely.

## Test plan
- Only A valid, waddr=5, wdata=0x1234_5678 → `a_ready_o`=1 the same cycle; next cycle `we_o`=1, `waddr_o`=5, `wdata_o`=0x1234_5678.
- A and B both valid for 10 cycles (A waddr=3, B waddr=7, `MAX_WAIT`=4), guard defined → A granted cycles 0–3; B granted at cycle 4 with `a_ready_o`=0; `b_forced_o`=1 the following cycle; counter restarts.
- Same stimulus with guard undefined → B never ready while A valid; `b_forced_o` stays 0.
- A waddr=0 and B waddr=9 valid together → both ready the same cycle; next cycle exactly one write, to register 9 with B's data.
- Reset asserted in the same cycle as an A grant → next cycle `we_o`=0, `starve_cnt`=0, both readies 0; after deassert, the held A request completes normally.
- Both ports target waddr=12 (A=0xAAAA_AAAA, B=0xBBBB_BBBB), guard defined → A written first, B one cycle later; final register 12 = 0xBBBB_BBBB.
